// File: rtl/mem_seq48_pkg.sv
// mem_seq48_pkg -- shared sizes for the 48-bit memory sequencer slice.
//   HBIT_ADDR : index of the top bit of a word address (address width - 1)
//   HBIT_DATA : index of the top bit of one SRAM word (word width - 1)
// FSM encodings stay local to mem_seq48 and are not shared here.
package mem_seq48_pkg;

  localparam int HBIT_ADDR = 47;
  localparam int HBIT_DATA = 23;

endpackage : mem_seq48_pkg

// File: rtl/mem_seq48_if.sv
// mem_seq48_if -- request/response bus plus the external SRAM port of mem_seq48.
//   iw_req_valid/ow_req_ready : request handshake (accept on valid & ready)
//   iw_req_we, iw_req_is48    : write select, two-word (48-bit) select
//   iw_req_addr, iw_req_wdata : word address, write data (low half = first word)
//   ow_rsp_valid/ow_rsp_rdata : one-cycle read-data strobe and data
//   ow_sram_*                 : SRAM enable, write strobe, address, write word
//   iw_sram_rdata             : SRAM read word, valid the cycle after the access
// Modports: slave = the sequencer, master = the requester/SRAM side.
interface mem_seq48_if
  import mem_seq48_pkg::*;
#(
  parameter int ADDR_W = HBIT_ADDR + 1,
  parameter int DATA_W = HBIT_DATA + 1
);

  logic                  iw_req_valid;
  logic                  ow_req_ready;
  logic                  iw_req_we;
  logic                  iw_req_is48;
  logic [ADDR_W-1:0]     iw_req_addr;
  logic [2*DATA_W-1:0]   iw_req_wdata;
  logic                  ow_rsp_valid;
  logic [2*DATA_W-1:0]   ow_rsp_rdata;
  logic                  ow_sram_en;
  logic                  ow_sram_we;
  logic [ADDR_W-1:0]     ow_sram_addr;
  logic [DATA_W-1:0]     ow_sram_wdata;
  logic [DATA_W-1:0]     iw_sram_rdata;

  modport slave (
    input  iw_req_valid, iw_req_we, iw_req_is48, iw_req_addr, iw_req_wdata,
    input  iw_sram_rdata,
    output ow_req_ready, ow_rsp_valid, ow_rsp_rdata,
    output ow_sram_en, ow_sram_we, ow_sram_addr, ow_sram_wdata
  );

  modport master (
    output iw_req_valid, iw_req_we, iw_req_is48, iw_req_addr, iw_req_wdata,
    output iw_sram_rdata,
    input  ow_req_ready, ow_rsp_valid, ow_rsp_rdata,
    input  ow_sram_en, ow_sram_we, ow_sram_addr, ow_sram_wdata
  );

endinterface : mem_seq48_if

// File: rtl/mem_seq48.sv
// mem_seq48 -- sequences single-word (24-bit) and two-word (48-bit) accesses
// onto an external single-port SRAM with one-cycle read latency.
//   iw_clk   : single clock, rising edge
//   iw_rst_n : asynchronous active-low reset
//   bus      : mem_seq48_if.slave (request handshake, read response, SRAM port)
// All outputs come straight from flops; they are computed from the next state
// so that an access accepted in cycle A drives the SRAM during cycle A+1.
module mem_seq48
  import mem_seq48_pkg::*;
#(
  parameter int ADDR_W = HBIT_ADDR + 1,
  parameter int DATA_W = HBIT_DATA + 1
) (
  input  logic         iw_clk,
  input  logic         iw_rst_n,
  mem_seq48_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_RCAP  = 3'd3,
    ST_RSP   = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic                  we_r, we_s;
  logic                  is48_r, is48_s;
  logic [ADDR_W-1:0]     addr_r, addr_s;
  logic [2*DATA_W-1:0]   wdata_r, wdata_s;
  logic [2*DATA_W-1:0]   rdata_r, rdata_s;
  logic                  ready_r, ready_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic                  sram_en_r, sram_en_s;
  logic                  sram_we_r, sram_we_s;
  logic [ADDR_W-1:0]     sram_addr_r, sram_addr_s;
  logic [DATA_W-1:0]     sram_wdata_r, sram_wdata_s;
  logic                  accept_s;

  // ready_r is still low on the first cycle after reset, so it gates acceptance
  assign accept_s = (state_r == ST_IDLE) && ready_r && bus.iw_req_valid;

  // Next-state logic and request latching
  always_comb begin
    state_s = state_r;
    we_s    = we_r;
    is48_s  = is48_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_BEAT0;
          we_s    = bus.iw_req_we;
          is48_s  = bus.iw_req_is48;
          addr_s  = bus.iw_req_addr;
          wdata_s = bus.iw_req_wdata;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (is48_r) begin
          state_s = ST_BEAT1;
        end else if (!we_r) begin
          state_s = ST_RCAP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BEAT1: begin
        if (!we_r) begin
          state_s = ST_RCAP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RCAP: state_s = ST_RSP;
      ST_RSP:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered SRAM port, handshake and response outputs
  always_comb begin
    sram_en_s    = 1'b0;
    sram_we_s    = 1'b0;
    sram_addr_s  = {ADDR_W{1'b0}};
    sram_wdata_s = {DATA_W{1'b0}};
    case (state_s)
      ST_BEAT0: begin
        sram_en_s    = 1'b1;
        sram_we_s    = we_s;
        sram_addr_s  = addr_s;
        sram_wdata_s = wdata_s[DATA_W-1:0];
      end
      ST_BEAT1: begin
        sram_en_s    = 1'b1;
        sram_we_s    = we_s;
        // wraps to word 0 at the top of the address space
        sram_addr_s  = addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
        sram_wdata_s = wdata_s[2*DATA_W-1:DATA_W];
      end
      default: begin
        sram_en_s    = 1'b0;
        sram_we_s    = 1'b0;
        sram_addr_s  = {ADDR_W{1'b0}};
        sram_wdata_s = {DATA_W{1'b0}};
      end
    endcase

    ready_s     = (state_s == ST_IDLE);
    rsp_valid_s = (state_s == ST_RSP);

    // SRAM data arrives one cycle after its beat: word a shows up in the
    // cycle after BEAT0 (BEAT1 for 48-bit, RCAP for 24-bit), word a+1 in RCAP.
    rdata_s = rdata_r;
    if ((state_r == ST_BEAT1) && !we_r) begin
      rdata_s[DATA_W-1:0] = bus.iw_sram_rdata;
    end else if (state_r == ST_RCAP) begin
      if (is48_r) begin
        rdata_s[2*DATA_W-1:DATA_W] = bus.iw_sram_rdata;
      end else begin
        rdata_s = {{DATA_W{1'b0}}, bus.iw_sram_rdata};
      end
    end else begin
      rdata_s = rdata_r;
    end
  end

  // State, latched request and output registers
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      is48_r       <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {(2*DATA_W){1'b0}};
      rdata_r      <= {(2*DATA_W){1'b0}};
      ready_r      <= 1'b0;
      rsp_valid_r  <= 1'b0;
      sram_en_r    <= 1'b0;
      sram_we_r    <= 1'b0;
      sram_addr_r  <= {ADDR_W{1'b0}};
      sram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      we_r         <= we_s;
      is48_r       <= is48_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
      ready_r      <= ready_s;
      rsp_valid_r  <= rsp_valid_s;
      sram_en_r    <= sram_en_s;
      sram_we_r    <= sram_we_s;
      sram_addr_r  <= sram_addr_s;
      sram_wdata_r <= sram_wdata_s;
    end
  end

  assign bus.ow_req_ready  = ready_r;
  assign bus.ow_rsp_valid  = rsp_valid_r;
  assign bus.ow_rsp_rdata  = rdata_r;
  assign bus.ow_sram_en    = sram_en_r;
  assign bus.ow_sram_we    = sram_we_r;
  assign bus.ow_sram_addr  = sram_addr_r;
  assign bus.ow_sram_wdata = sram_wdata_r;

endmodule : mem_seq48

// File: tb/tb_mem_seq48.sv
// tb_mem_seq48 -- scoreboard bench for mem_seq48 with a single-port SRAM model
// (one-cycle read latency). Stimulus pushes expected SRAM writes and read
// responses into queues; a negedge monitor pops and compares them.
module tb_mem_seq48;

  localparam int AW = 48;
  localparam int DW = 24;

  typedef struct {
    int          cyc;
    logic [47:0] data;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [47:0] addr;
    logic [23:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [23:0] mem [0:255];

  mem_seq48_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_seq48 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iw_clk  (clk),
    .iw_rst_n(rst_n),
    .bus     (bus)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // single-port SRAM model, folded onto 256 words (addresses used do not alias)
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;
    bus.iw_sram_rdata = 24'h0;
  end
  always @(posedge clk) begin
    if (bus.ow_sram_en) begin
      if (bus.ow_sram_we) mem[bus.ow_sram_addr[7:0]] <= bus.ow_sram_wdata;
      else                bus.iw_sram_rdata <= mem[bus.ow_sram_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: compare every SRAM write and every response against the queues
  always @(negedge clk) begin
    if (bus.ow_sram_en && bus.ow_sram_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_sram_write", {16'h0, bus.ow_sram_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(w.cyc));
        chk("wr_addr", {16'h0, bus.ow_sram_addr}, {16'h0, w.addr});
        chk("wr_data", {40'h0, bus.ow_sram_wdata}, {40'h0, w.data});
      end
    end
    if (bus.ow_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp_valid", {16'h0, bus.ow_rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
        chk("rsp_rdata", {16'h0, bus.ow_rsp_rdata}, {16'h0, r.data});
      end
    end
  end

  // Issue one request, hold valid until accepted, push expectations.
  task automatic issue(input logic we, input logic is48, input logic [47:0] addr,
                       input logic [47:0] wdata, input logic [47:0] exp_rd,
                       input bit expect_rsp, output int acc);
    int n;
    @(negedge clk);
    bus.iw_req_valid = 1'b1;
    bus.iw_req_we    = we;
    bus.iw_req_is48  = is48;
    bus.iw_req_addr  = addr;
    bus.iw_req_wdata = wdata;
    n = 0;
    while (!bus.ow_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 50) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.iw_req_valid = 1'b0;
    end else begin
      if (we) begin
        wr_q.push_back('{cyc: acc + 1, addr: addr, data: wdata[23:0]});
        if (is48) wr_q.push_back('{cyc: acc + 2, addr: addr + 48'd1, data: wdata[47:24]});
      end else if (expect_rsp) begin
        rsp_q.push_back('{cyc: (is48 ? acc + 4 : acc + 3), data: exp_rd});
      end
      @(posedge clk);
      #1 bus.iw_req_valid = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},      {63'h0, bus.ow_req_ready}, 64'h0);
    chk({tag, "_rsp_valid"},  {63'h0, bus.ow_rsp_valid}, 64'h0);
    chk({tag, "_rsp_rdata"},  {16'h0, bus.ow_rsp_rdata}, 64'h0);
    chk({tag, "_sram_en"},    {63'h0, bus.ow_sram_en}, 64'h0);
    chk({tag, "_sram_we"},    {63'h0, bus.ow_sram_we}, 64'h0);
    chk({tag, "_sram_addr"},  {16'h0, bus.ow_sram_addr}, 64'h0);
    chk({tag, "_sram_wdata"}, {40'h0, bus.ow_sram_wdata}, 64'h0);
  endtask

  initial begin
    int a, a2;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.iw_req_valid = 1'b0;
    bus.iw_req_we    = 1'b0;
    bus.iw_req_is48  = 1'b0;
    bus.iw_req_addr  = 48'h0;
    bus.iw_req_wdata = 48'h0;

    // reset state, and ready one edge after release
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {63'h0, bus.ow_req_ready}, 64'h0);
    @(posedge clk);
    #1 chk("ready_after_reset", {63'h0, bus.ow_req_ready}, 64'h1);

    // 48-bit write at 12; ready low at A+1, A+2 and high at A+3
    issue(1'b1, 1'b1, 48'd12, 48'h123456_ABCDEF, 48'h0, 1'b0, a);
    for (int k = 1; k <= 3; k++) begin
      while (cyc < a + k) @(negedge clk);
      chk("w48_ready", {63'h0, bus.ow_req_ready}, (k == 3) ? 64'h1 : 64'h0);
    end

    // 48-bit read back at 12
    issue(1'b0, 1'b1, 48'd12, 48'h0, 48'h123456_ABCDEF, 1'b1, a);

    // 24-bit write then read at 40; word 41 untouched; high half zeroed
    issue(1'b1, 1'b0, 48'd40, 48'h000000_00FACE, 48'h0, 1'b0, a);
    while (cyc < a + 2) @(negedge clk);
    chk("w24_ready", {63'h0, bus.ow_req_ready}, 64'h1);
    issue(1'b0, 1'b0, 48'd40, 48'h0, 48'h000000_00FACE, 1'b1, a);
    repeat (4) @(negedge clk);
    chk("word41_untouched", {40'h0, mem[41]}, 64'h0);

    // 48-bit write at the top address: second beat wraps to 0
    issue(1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 48'h0A0B0C_0D0E0F, 48'h0, 1'b0, a);
    issue(1'b0, 1'b0, 48'd0, 48'h0, 48'h000000_0A0B0C, 1'b1, a);

    // request held valid during a busy 48-bit write: accepted once, at A+3
    issue(1'b1, 1'b1, 48'd100, 48'h333333_444444, 48'h0, 1'b0, a);
    issue(1'b1, 1'b0, 48'd110, 48'h000000_222222, 48'h0, 1'b0, a2);
    chk("held_accept_cycle", 64'(a2), 64'(a + 3));
    repeat (4) @(negedge clk);

    // reset during BEAT1 of a 48-bit read: no response, outputs zero at once
    issue(1'b0, 1'b1, 48'd12, 48'h0, 48'h0, 1'b0, a);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midreset_ready_low", {63'h0, bus.ow_req_ready}, 64'h0);
    @(posedge clk);
    #1 chk("midreset_ready_back", {63'h0, bus.ow_req_ready}, 64'h1);
    repeat (6) @(negedge clk);

    // still functional after the aborted access
    issue(1'b0, 1'b0, 48'd40, 48'h0, 48'h000000_00FACE, 1'b1, a);
    repeat (8) @(negedge clk);

    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    chk("wr_queue_drained", 64'(wr_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_seq48

// File: doc/mem_seq48.md
MEM_SEQ48 -- requirements
Module: mem_seq48

Interface
REQ-001 SHALL have parameter ADDR_W, default 48, address width (HBIT_ADDR+1).
REQ-002 SHALL have parameter DATA_W, default 24, SRAM word width (HBIT_DATA+1).
REQ-003 SHALL have port iw_clk, input, 1, the single clock; all flops rise-edge.
REQ-004 SHALL have port iw_rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port iw_req_valid, input, 1, request present.
REQ-006 SHALL have port ow_req_ready, output, 1, request accepted when high with valid.
REQ-007 SHALL have port iw_req_we, input, 1, 1=write, 0=read.
REQ-008 SHALL have port iw_req_is48, input, 1, 1=48-bit (two-word) access, 0=single word.
REQ-009 SHALL have port iw_req_addr, input, ADDR_W, word address.
REQ-010 SHALL have port iw_req_wdata, input, 2*DATA_W, write data; [DATA_W-1:0] low half.
REQ-011 SHALL have port ow_rsp_valid, output, 1, one-cycle read-data strobe.
REQ-012 SHALL have port ow_rsp_rdata, output, 2*DATA_W, read data.
REQ-013 SHALL have port ow_sram_en, output, 1, SRAM access this cycle.
REQ-014 SHALL have port ow_sram_we, output, 1, SRAM write strobe.
REQ-015 SHALL have port ow_sram_addr, output, ADDR_W, SRAM word address.
REQ-016 SHALL have port ow_sram_wdata, output, DATA_W, SRAM write word.
REQ-017 SHALL have port iw_sram_rdata, input, DATA_W, SRAM read word, valid the cycle after the addressed cycle.

Function
REQ-018 SHALL implement FSM states IDLE, BEAT0, BEAT1, RCAP, RSP; ow_req_ready is a flop, high only in IDLE.
REQ-019 SHALL accept a request at the edge ending a cycle with valid&ready and latch we, is48, addr, wdata; accept cycle A -> BEAT0 in A+1.
REQ-020 SHALL in BEAT0 drive sram_en=1, sram_we=we, addr=a, wdata=low half.
REQ-021 SHALL in BEAT1 (is48 only) drive sram_en=1, sram_we=we, addr=a+1 mod 2^ADDR_W, wdata=high half.
REQ-022 SHALL transition BEAT0 -> BEAT1 if is48; else -> RCAP if read; else -> IDLE.
REQ-023 SHALL transition BEAT1 -> RCAP if read, else -> IDLE.
REQ-024 SHALL capture iw_sram_rdata as low half in the cycle after BEAT0 (BEAT1 or RCAP) and as high half in RCAP when is48.
REQ-025 SHALL zero the high half of rsp_rdata for 24-bit reads.
REQ-026 SHALL transition RCAP -> RSP; RSP asserts ow_rsp_valid one cycle with the registered rdata; RSP -> IDLE.
REQ-027 SHALL meet these latencies from accept cycle A: 24-bit write ready at A+2; 48-bit write ready at A+3; 24-bit read rsp_valid at A+3; 48-bit read rsp_valid at A+4.
REQ-028 SHALL drive sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0 in IDLE, RCAP, RSP.
REQ-029 SHALL ignore iw_req_* whenever ready is low; no queueing.
REQ-030 SHALL hold ow_rsp_rdata stable after RSP until the next read's RCAP.

Reset
REQ-031 SHALL while iw_rst_n=0 force state IDLE, ow_req_ready=0, ow_rsp_valid=0, ow_rsp_rdata=0, and all ow_sram_* to 0, asynchronously.
REQ-032 SHALL set ow_req_ready=1 on the first rising edge after iw_rst_n rises.
REQ-033 SHALL on reset mid-operation abort the access with no rsp_valid; a 48-bit write cut after BEAT0 leaves only word a written.

Structure
REQ-034 SHALL take widths from the shared sizes header (HBIT_ADDR, HBIT_DATA); FSM state encodings are local parameters, not shared.
REQ-035 SHALL be a single module with no sub-module; the SRAM is external (bench uses the existing single-port mem model at READ_MEM=0).

Verification
REQ-036 SHALL test 48-bit write at addr 12, data 0x123456_ABCDEF: SRAM writes word 12=0xABCDEF at A+1 and word 13=0x123456 at A+2, and ready is high at A+3.
REQ-037 SHALL test a 48-bit read at addr 12 after REQ-036: rsp_valid pulses exactly at A+4 with rdata 0x123456_ABCDEF.
REQ-038 SHALL test 24-bit write 0x00FACE at addr 40, then 24-bit read of addr 40: rsp_valid pulses at A+3 with rdata 0x000000_00FACE; word 41 is untouched.
REQ-039 SHALL test a 48-bit write at addr 0xFFFF_FFFF_FFFF: the second beat addresses 0.
REQ-040 SHALL test a request held valid during a busy access: it is accepted only at the first ready cycle and is not duplicated.
REQ-041 SHALL test assertion of iw_rst_n=0 during BEAT1 of a 48-bit read: all outputs go to 0 immediately, no rsp_valid occurs, and ready returns one edge after release.
